// File: rtl/uart_frame_deserializer_if.sv
// Bus between the UART RX FIFO / score consumers and the frame deserializer.
// Handshake: the FIFO side presents rx_data while rx_empty=0; the deserializer
// raises rd_uart in the same cycle, and the byte is consumed at the rising edge
// where rd_uart=1. data_valid / frame_err are single-cycle pulses with no
// back-pressure. dbg_state mirrors the receive FSM for observation.
interface uart_frame_deserializer_if;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rd_uart;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic [7:0]  frame_cnt;
  logic        link_alive;
  logic [2:0]  dbg_state;

  modport master (
    output rx_empty, rx_data,
    input  rd_uart, data_out, data_valid, frame_err, frame_cnt, link_alive, dbg_state
  );

  modport slave (
    input  rx_empty, rx_data,
    output rd_uart, data_out, data_valid, frame_err, frame_cnt, link_alive, dbg_state
  );
endinterface

// File: rtl/uart_frame_deserializer.sv
// Receive side of the inter-board score link: hunts for SYNC_BYTE in the RX FIFO
// stream, assembles D3..D0, checks the XOR checksum, publishes good words and
// tracks byte-level and link-level timeouts.
module uart_frame_deserializer #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         BYTE_TIMEOUT = 1000,
  parameter int         LINK_TIMEOUT = 75_000_000
) (
  input logic                      pclk,
  input logic                      rst,
  uart_frame_deserializer_if.slave bus
);

  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int LT_W = $clog2(LINK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_D3   = 3'd1,
    S_D2   = 3'd2,
    S_D1   = 3'd3,
    S_D0   = 3'd4,
    S_CHK  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  xor_q, xor_d;
  logic [BT_W-1:0] btimer_q, btimer_d;
  logic [LT_W-1:0] ltimer_q, ltimer_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        alive_q, alive_d;
  logic        pop;
  logic        good;

  // The block is always ready: pop whenever the FIFO has a byte and we are not in reset.
  assign pop         = !bus.rx_empty && !rst;
  assign bus.rd_uart = pop;

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.frame_cnt  = cnt_q;
  assign bus.link_alive = alive_q;
  assign bus.dbg_state  = state_q;

  // Next-state logic: frame FSM, payload assembly, byte timer and link timer.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    xor_d    = xor_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    alive_d  = alive_q;
    ltimer_d = ltimer_q;
    good     = 1'b0;

    // Byte timer only runs while waiting inside a frame.
    if (pop || state_q == S_HUNT) begin
      btimer_d = '0;
    end else begin
      btimer_d = btimer_q + 1'b1;
    end

    unique case (state_q)
      S_HUNT: begin
        if (pop && bus.rx_data == SYNC_BYTE) begin
          state_d = S_D3;
          xor_d   = '0;
        end
      end
      S_D3, S_D2, S_D1, S_D0: begin
        // SYNC_BYTE is ordinary data here; no escaping is used on this link.
        if (pop) begin
          shift_d = {shift_q[23:0], bus.rx_data};
          xor_d   = xor_q ^ bus.rx_data;
          state_d = state_t'(state_q + 3'd1);
        end
      end
      S_CHK: begin
        if (pop) begin
          if (bus.rx_data == xor_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            good    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase

    // A stalled frame is abandoned; a pop in the same cycle takes precedence.
    if (state_q != S_HUNT && !pop && btimer_q == BT_W'(BYTE_TIMEOUT)) begin
      state_d  = S_HUNT;
      err_d    = 1'b1;
      btimer_d = '0;
    end

    // A good frame refreshes the link even on the cycle it would have expired.
    if (good) begin
      ltimer_d = '0;
      alive_d  = 1'b1;
    end else if (alive_q) begin
      if (ltimer_q == LT_W'(LINK_TIMEOUT - 1)) begin
        alive_d  = 1'b0;
        ltimer_d = '0;
      end else begin
        ltimer_d = ltimer_q + 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= S_HUNT;
      shift_q  <= '0;
      xor_q    <= '0;
      btimer_q <= '0;
      ltimer_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      xor_q    <= xor_d;
      btimer_q <= btimer_d;
      ltimer_q <= ltimer_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      alive_q  <= alive_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_deserializer.sv
// Bench for uart_frame_deserializer with short timeouts so byte and link
// expiry are reachable in a few cycles.
module tb_uart_frame_deserializer;
  localparam int BT = 8;
  localparam int LT = 16;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  uart_frame_deserializer_if bus();

  uart_frame_deserializer #(
    .SYNC_BYTE(8'hA5),
    .BYTE_TIMEOUT(BT),
    .LINK_TIMEOUT(LT)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ---------------- reference model ----------------
  logic [7:0]  m_frame[$];
  bit          m_in_frame  = 0;
  int          m_last_pop  = 0;
  int          m_last_good = 0;
  bit          m_have_good = 0;
  logic [31:0] m_data      = '0;
  bit          m_valid     = 0;
  bit          m_err       = 0;
  logic [7:0]  m_cnt       = '0;
  logic [31:0] exp_q[$];

  // Model: updates expectations from the inputs seen at each rising edge.
  always @(posedge pclk) begin
    cyc++;
    m_valid = 0;
    m_err   = 0;
    if (rst) begin
      m_in_frame  = 0;
      m_frame.delete();
      m_data      = '0;
      m_cnt       = '0;
      m_have_good = 0;
    end else if (!bus.rx_empty) begin
      m_last_pop = cyc;
      if (!m_in_frame) begin
        if (bus.rx_data == 8'hA5) begin
          m_in_frame = 1;
          m_frame.delete();
        end
      end else begin
        m_frame.push_back(bus.rx_data);
        if (m_frame.size() == 5) begin
          if ((m_frame[0] ^ m_frame[1] ^ m_frame[2] ^ m_frame[3]) == m_frame[4]) begin
            m_data      = {m_frame[0], m_frame[1], m_frame[2], m_frame[3]};
            m_valid     = 1;
            m_cnt       = m_cnt + 8'd1;
            m_have_good = 1;
            m_last_good = cyc;
            exp_q.push_back(m_data);
          end else begin
            m_err = 1;
          end
          m_in_frame = 0;
        end
      end
    end else if (m_in_frame && (cyc - m_last_pop) == BT + 1) begin
      m_err      = 1;
      m_in_frame = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  int  last_valid_cyc = 0;
  int  last_err_cyc   = 0;
  int  fall_cyc       = 0;
  bit  prev_alive     = 0;

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge pclk) begin
    if (cyc > 0) begin
      bit exp_alive;
      logic [31:0] w;
      exp_alive = m_have_good && ((cyc - m_last_good) <= LT - 1);
      chk("data_out",   bus.data_out, m_data);
      chk("data_valid", 32'(bus.data_valid), 32'(m_valid));
      chk("frame_err",  32'(bus.frame_err), 32'(m_err));
      chk("frame_cnt",  32'(bus.frame_cnt), 32'(m_cnt));
      chk("link_alive", 32'(bus.link_alive), 32'(exp_alive));
      chk("rd_uart",    32'(bus.rd_uart), 32'(!bus.rx_empty && !rst));
      if (bus.data_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_word cyc=%0d act=%h exp=<none>", cyc, bus.data_out);
        end else begin
          w = exp_q.pop_front();
          if (w !== bus.data_out) begin
            failures++;
            $display("FAIL sb_word cyc=%0d act=%h exp=%h", cyc, bus.data_out, w);
          end
        end
        last_valid_cyc = cyc;
      end
      if (bus.frame_err) last_err_cyc = cyc;
      if (prev_alive && !bus.link_alive) fall_cyc = cyc;
      prev_alive = bus.link_alive;
    end
  end

  // ---------------- driver tasks ----------------
  int last_pop_cyc = 0;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_empty = 1'b0;
    bus.rx_data  = b;
    @(posedge pclk);
    #1;
    last_pop_cyc = cyc;
    bus.rx_empty = 1'b1;
    bus.rx_data  = 8'($urandom_range(0, 255));
  endtask

  // Gaps: 0 = back to back; otherwise occasional stalls around the byte timeout.
  task automatic send_frame(input logic [31:0] w, input bit good, input bit gaps);
    logic [7:0] c;
    logic [7:0] b[5];
    c = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    if (!good) c = c ^ 8'($urandom_range(1, 255));
    b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0]; b[4] = c;
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) begin
      if (gaps) begin
        if ($urandom_range(0, 7) == 0) idle($urandom_range(BT - 1, BT + 2));
        else idle($urandom_range(0, 2));
      end
      send_byte(b[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pop22;
    int vcyc;
    bus.rx_empty = 1'b1;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    idle(2);
    chk("rst_data_out",   bus.data_out, 32'h0);
    chk("rst_data_valid", 32'(bus.data_valid), 32'h0);
    chk("rst_frame_err",  32'(bus.frame_err), 32'h0);
    chk("rst_frame_cnt",  32'(bus.frame_cnt), 32'h0);
    chk("rst_link_alive", 32'(bus.link_alive), 32'h0);
    chk("rst_state",      32'(bus.dbg_state), 32'h0);
    rst = 1'b0;
    idle(2);

    // Basic good frame.
    send_frame(32'h12345678, 1, 0);
    chk("t1_valid", 32'(bus.data_valid), 32'h1);
    chk("t1_data",  bus.data_out, 32'h12345678);
    chk("t1_cnt",   32'(bus.frame_cnt), 32'h1);
    chk("t1_alive", 32'(bus.link_alive), 32'h1);
    idle(1);
    chk("t1_pulse", 32'(bus.data_valid), 32'h0);

    // Bad checksum.
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h56); send_byte(8'h78); send_byte(8'h09);
    chk("t2_err",  32'(bus.frame_err), 32'h1);
    chk("t2_data", bus.data_out, 32'h12345678);
    chk("t2_cnt",  32'(bus.frame_cnt), 32'h1);

    // Garbage before sync.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    chk("t3_noerr", 32'(bus.frame_err), 32'h0);
    send_byte(8'hA5); send_byte(8'hDE); send_byte(8'hAD);
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h22);
    chk("t3_data", bus.data_out, 32'hDEADBEEF);

    // SYNC byte as payload.
    send_frame(32'hA5A5A5A5, 1, 0);
    chk("t4_data", bus.data_out, 32'hA5A5A5A5);
    chk("t4_cnt",  32'(bus.frame_cnt), 32'h3);

    // Intra-frame timeout.
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
    pop22 = last_pop_cyc;
    idle(20);
    chk("t5_err_latency", 32'(last_err_cyc - pop22), 32'd9);
    send_frame(32'h01020304, 1, 0);
    chk("t5_data", bus.data_out, 32'h01020304);

    // Link expiry.
    send_frame(32'h55AA0F0F, 1, 0);
    vcyc = last_pop_cyc;
    idle(30);
    chk("t6_link_fall", 32'(fall_cyc - vcyc), 32'd16);
    chk("t6_alive", 32'(bus.link_alive), 32'h0);

    // Reset during D1 with a byte offered while reset is high.
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    bus.rx_empty = 1'b0;
    bus.rx_data  = 8'h33;
    idle(1);
    rst = 1'b0;
    bus.rx_empty = 1'b1;
    send_frame(32'hCAFEF00D, 1, 0);
    chk("t7_data", bus.data_out, 32'hCAFEF00D);
    chk("t7_cnt",  32'(bus.frame_cnt), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 39);
      if (kind == 0) begin
        do_reset();
      end else if (kind < 6) begin
        send_byte(8'($urandom_range(0, 255)));
      end else if (kind < 12) begin
        send_frame($urandom, 0, $urandom_range(0, 1));
      end else begin
        send_frame($urandom, 1, $urandom_range(0, 1));
      end
      idle($urandom_range(0, 3));
    end
    idle(BT + 4);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 255; i++) send_frame($urandom, 1, 0);
    chk("wrap_255", 32'(bus.frame_cnt), 32'd255);
    send_frame($urandom, 1, 0);
    chk("wrap_0", 32'(bus.frame_cnt), 32'd0);
    idle(4);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
